// File: rtl/fft16_bf_sched_pkg.sv
// Shared constants, state encoding and width helper for the radix-2 DIF butterfly scheduler.
package fft16_bf_sched_pkg;

  localparam int N    = 16;
  localparam int LOGN = 4;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  localparam int AW = LOGN;
  localparam int KW = LOGN - 1;
  localparam int SW = (clog2(LOGN) < 1) ? 1 : clog2(LOGN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/fft16_bf_sched_delay.sv
// Fixed-depth register line that turns the read-side control into the matching write-side control.
module fft_bf_delay #(
  parameter int DEPTH = 2,
  parameter int W     = 9
) (
  input  logic         iCLK,
  input  logic         iRSTn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] line_q [DEPTH];

  // NOTE: this line is control, not a data memory, so it is cleared; reset must kill in-flight writes.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign q_o = line_q[DEPTH-1];

endmodule

// File: rtl/fft16_bf_sched.sv
// Sequencer for one shared radix-2 butterfly of an in-place DIF FFT: walks stages x butterflies,
// generates RAM read/write addresses and twiddle index, and runs the start/busy/done handshake.
module fft16_bf_sched
  import fft16_bf_sched_pkg::*;
#(
  parameter int PIPE_LAT = 2
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iSTART,
  output logic          oBUSY,
  output logic          oDONE,
  output logic [SW-1:0] oSTAGE,
  output logic          oRD_EN,
  output logic [AW-1:0] oRD_ADDR_A,
  output logic [AW-1:0] oRD_ADDR_B,
  output logic [KW-1:0] oTW_IDX,
  output logic          oWR_EN,
  output logic [AW-1:0] oWR_ADDR_A,
  output logic [AW-1:0] oWR_ADDR_B
);

  localparam int DW = (clog2(PIPE_LAT + 1) < 1) ? 1 : clog2(PIPE_LAT + 1);
  localparam logic [KW-1:0] K_LAST     = KW'(N / 2 - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(LOGN - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] drain_q, drain_d;

  logic          busy_q, done_q, rd_en_q;
  logic [AW-1:0] addr_a_q, addr_b_q, addr_a_d, addr_b_d;
  logic [KW-1:0] tw_q, tw_d;
  logic [AW-1:0] span, pos;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          state_d = S_RUN;
          stage_d = '0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            stage_d = stage_q + SW'(1);
            k_d     = '0;
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Butterfly k of stage s: clearing the low (span-1) bits of k and doubling gives grp*2*span.
  always_comb begin
    span     = AW'(N / 2) >> stage_d;
    pos      = {1'b0, k_d} & (span - AW'(1));
    addr_a_d = (({1'b0, k_d} & ~(span - AW'(1))) << 1) | pos;
    addr_b_d = addr_a_d | span;
    tw_d     = KW'(pos << stage_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q  <= S_IDLE;
      stage_q  <= '0;
      k_q      <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
      rd_en_q <= (state_d == S_RUN);
      if (state_d == S_RUN) begin
        addr_a_q <= addr_a_d;
        addr_b_q <= addr_b_d;
        tw_q     <= tw_d;
      end
    end
  end

  fft_bf_delay #(
    .DEPTH (PIPE_LAT),
    .W     (1 + 2 * AW)
  ) u_delay (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .d_i   ({rd_en_q, addr_a_q, addr_b_q}),
    .q_o   ({oWR_EN, oWR_ADDR_A, oWR_ADDR_B})
  );

  assign oBUSY      = busy_q;
  assign oDONE      = done_q;
  assign oSTAGE     = stage_q;
  assign oRD_EN     = rd_en_q;
  assign oRD_ADDR_A = addr_a_q;
  assign oRD_ADDR_B = addr_b_q;
  assign oTW_IDX    = tw_q;

endmodule

// File: tb/tb_fft16_bf_sched.sv
// Bench for fft16_bf_sched: cycle-timing model, address vectors, and a real-valued RAM/butterfly
// datapath whose memory after each run is compared with a direct DFT of random Q15 input.
module tb_fft16_bf_sched;
  import fft16_bf_sched_pkg::*;

  parameter int PIPE_LAT = 2;

  localparam int  NH       = N / 2;
  localparam int  STAGE_P  = NH + PIPE_LAT;
  localparam int  RUN_CYC  = LOGN * STAGE_P;
  localparam int  DONE_CYC = RUN_CYC + 1;
  localparam real PI       = 3.14159265358979323846;
  localparam real TOL      = 1.0e-9;

  logic          iCLK, iRSTn, iSTART;
  logic          oBUSY, oDONE, oRD_EN, oWR_EN;
  logic [SW-1:0] oSTAGE;
  logic [AW-1:0] oRD_ADDR_A, oRD_ADDR_B, oWR_ADDR_A, oWR_ADDR_B;
  logic [KW-1:0] oTW_IDX;

  fft16_bf_sched #(.PIPE_LAT(PIPE_LAT)) dut (
    .iCLK       (iCLK),
    .iRSTn      (iRSTn),
    .iSTART     (iSTART),
    .oBUSY      (oBUSY),
    .oDONE      (oDONE),
    .oSTAGE     (oSTAGE),
    .oRD_EN     (oRD_EN),
    .oRD_ADDR_A (oRD_ADDR_A),
    .oRD_ADDR_B (oRD_ADDR_B),
    .oTW_IDX    (oTW_IDX),
    .oWR_EN     (oWR_EN),
    .oWR_ADDR_A (oWR_ADDR_A),
    .oWR_ADDR_B (oWR_ADDR_B)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_real(input string name, input real act, input real exp);
    total++;
    if ((act - exp > TOL) || (exp - act > TOL)) begin
      bad++;
      $display("FAIL %s: got %f expected %f", name, act, exp);
    end
  endtask

  typedef struct {
    int stage;
    int k;
    int a;
    int b;
    int tw;
  } vec_t;
  vec_t vecs[6];

  typedef struct {
    int  a;
    int  b;
    int  c;
    int  s;
    real sr;
    real si;
    real dr;
    real di;
  } rd_t;
  rd_t rdq[$];

  real mre[N], mim[N], xre[N], xim[N];

  function automatic int ref_span(input int s);
    return N / (2 ** (s + 1));
  endfunction

  function automatic int ref_a(input int s, input int k);
    int sp;
    sp = ref_span(s);
    return (k / sp) * 2 * sp + (k % sp);
  endfunction

  function automatic int bitrev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < LOGN; i++) if ((v >> i) & 1) r |= 1 << (LOGN - 1 - i);
    return r;
  endfunction

  function automatic longint all_outs();
    return longint'({oBUSY, oDONE, oSTAGE, oRD_EN, oRD_ADDR_A, oRD_ADDR_B, oTW_IDX,
                     oWR_EN, oWR_ADDR_A, oWR_ADDR_B});
  endfunction

  // One complete transform. iSTART is sampled at the next rising edge (cycle 0).
  // hold keeps iSTART high throughout; p1/p2 are cycles at which an extra iSTART pulse is driven.
  task automatic run_one(input bit hold, input int p1, input int p2);
    longint rd_mask[LOGN], wr_mask[LOGN];
    int     first_rd[LOGN], last_wr[LOGN];
    for (int s = 0; s < LOGN; s++) begin
      rd_mask[s] = 0; wr_mask[s] = 0; first_rd[s] = -1; last_wr[s] = -1;
    end
    for (int n = 0; n < N; n++) begin
      mre[n] = real'(int'($urandom_range(65535)) - 32768) / 32768.0;
      mim[n] = real'(int'($urandom_range(65535)) - 32768) / 32768.0;
      xre[n] = mre[n];
      xim[n] = mim[n];
    end
    rdq.delete();
    iSTART = 1'b1;
    @(posedge iCLK);
    for (int c = 1; c <= DONE_CYC + 1; c++) begin
      int  s, off, cw, k;
      bit  e_rd, e_wr, e_busy, e_done;
      @(negedge iCLK);
      if (!hold) iSTART = (c == p1) || (c == p2);
      s      = (c - 1) / STAGE_P;
      off    = (c - 1) % STAGE_P;
      cw     = c - PIPE_LAT;
      e_rd   = (c <= RUN_CYC) && (off < NH);
      e_wr   = (cw >= 1) && (cw <= RUN_CYC) && (((cw - 1) % STAGE_P) < NH);
      e_busy = (c <= RUN_CYC);
      e_done = (c == DONE_CYC);
      check($sformatf("ctl{busy,done,rd,wr} c=%0d", c),
            {oBUSY, oDONE, oRD_EN, oWR_EN}, {e_busy, e_done, e_rd, e_wr});

      if (oRD_EN) begin
        rd_t r;
        real cr, sn;
        if (e_rd) begin
          k = off;
          check($sformatf("stage c=%0d", c), oSTAGE, s);
          check($sformatf("rdA s=%0d k=%0d", s, k), oRD_ADDR_A, ref_a(s, k));
          check($sformatf("rdB s=%0d k=%0d", s, k), oRD_ADDR_B, ref_a(s, k) + ref_span(s));
          check($sformatf("tw s=%0d k=%0d", s, k), oTW_IDX,
                ((k % ref_span(s)) * (2 ** s)) % NH);
          foreach (vecs[i]) begin
            if (vecs[i].stage == s && vecs[i].k == k) begin
              check($sformatf("vec%0d A", i), oRD_ADDR_A, vecs[i].a);
              check($sformatf("vec%0d B", i), oRD_ADDR_B, vecs[i].b);
              check($sformatf("vec%0d TW", i), oTW_IDX, vecs[i].tw);
            end
          end
          if (first_rd[s] < 0) first_rd[s] = c;
          rd_mask[s] |= (64'd1 << oRD_ADDR_A) | (64'd1 << oRD_ADDR_B);
        end
        r.a  = int'(oRD_ADDR_A);
        r.b  = int'(oRD_ADDR_B);
        r.c  = c;
        r.s  = s;
        cr   = $cos(2.0 * PI * real'(oTW_IDX) / real'(N));
        sn   = $sin(2.0 * PI * real'(oTW_IDX) / real'(N));
        r.sr = mre[r.a] + mre[r.b];
        r.si = mim[r.a] + mim[r.b];
        r.dr = (mre[r.a] - mre[r.b]) * cr + (mim[r.a] - mim[r.b]) * sn;
        r.di = (mim[r.a] - mim[r.b]) * cr - (mre[r.a] - mre[r.b]) * sn;
        rdq.push_back(r);
      end

      if (oWR_EN) begin
        if (rdq.size() == 0) begin
          check($sformatf("write without read c=%0d", c), 1, 0);
        end else begin
          rd_t r;
          r = rdq.pop_front();
          check($sformatf("wrA c=%0d", c), oWR_ADDR_A, r.a);
          check($sformatf("wrB c=%0d", c), oWR_ADDR_B, r.b);
          check($sformatf("wr delay c=%0d", c), c - r.c, PIPE_LAT);
          mre[r.a] = r.sr; mim[r.a] = r.si;
          mre[r.b] = r.dr; mim[r.b] = r.di;
          if (r.s >= 0 && r.s < LOGN) begin
            last_wr[r.s] = c;
            wr_mask[r.s] |= (64'd1 << r.a) | (64'd1 << r.b);
          end
        end
      end

      if (c == DONE_CYC) begin
        for (int st = 0; st < LOGN; st++) begin
          check($sformatf("read cover s=%0d", st), rd_mask[st], (64'd1 << N) - 1);
          check($sformatf("write cover s=%0d", st), wr_mask[st], (64'd1 << N) - 1);
          if (st < LOGN - 1)
            check($sformatf("stage gap s=%0d", st), first_rd[st+1] - last_wr[st], 1);
        end
        for (int kk = 0; kk < N; kk++) begin
          real er, ei;
          er = 0.0; ei = 0.0;
          for (int n = 0; n < N; n++) begin
            real th;
            th = 2.0 * PI * real'(n * kk) / real'(N);
            er += xre[n] * $cos(th) + xim[n] * $sin(th);
            ei += xim[n] * $cos(th) - xre[n] * $sin(th);
          end
          check_real($sformatf("X[%0d].re", kk), mre[bitrev(kk)], er);
          check_real($sformatf("X[%0d].im", kk), mim[bitrev(kk)], ei);
        end
      end
    end
    check("pending writes after run", rdq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{stage: 0, k: 3, a: 3,  b: 11, tw: 3};
    vecs[1] = '{stage: 1, k: 5, a: 9,  b: 13, tw: 2};
    vecs[2] = '{stage: 3, k: 5, a: 10, b: 11, tw: 0};
    vecs[3] = '{stage: 0, k: 7, a: 7,  b: 15, tw: 7};
    vecs[4] = '{stage: 2, k: 1, a: 1,  b: 3,  tw: 4};
    vecs[5] = '{stage: 2, k: 6, a: 12, b: 14, tw: 0};

    iRSTn  = 1'b0;
    iSTART = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      check($sformatf("outputs in reset %0d", i), all_outs(), 0);
    end
    iRSTn = 1'b1;
    @(negedge iCLK);
    check("outputs idle after reset", all_outs(), 0);

    // Plain run, then a run with stray iSTART pulses that must be ignored.
    run_one(1'b0, 0, 0);
    run_one(1'b0, 5, 20);

    // iSTART held high: the second run starts on the cycle after oDONE.
    run_one(1'b1, 0, 0);
    run_one(1'b1, 0, 0);
    iSTART = 1'b0;
    @(negedge iCLK);

    // Reset in the middle of stage 1 while reads and writes are both active.
    iSTART = 1'b1;
    @(posedge iCLK);
    for (int c = 1; c <= 17; c++) begin
      @(negedge iCLK);
      iSTART = 1'b0;
    end
    check("rd active before mid-run reset", {oRD_EN, oWR_EN}, 2'b11);
    iRSTn = 1'b0;
    #1;
    check("outputs zero on async reset", all_outs(), 0);
    repeat (2) @(negedge iCLK);
    check("outputs zero held in reset", all_outs(), 0);
    iRSTn = 1'b1;
    @(negedge iCLK);
    check("idle after mid-run reset", all_outs(), 0);
    run_one(1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
